array_19_port_ctrl: RTL and testbench
=====================================

Name: array_19_port_ctrl

Overview:
- Front-end controller for the 4096x137 single-port RW0 SRAM macro (array_19_ext).
- Accepts independent valid/ready write and read-request streams and arbitrates them onto the single RW port.
- Tracks the macro's 1-cycle read latency and captures read data into a small response buffer with consumer backpressure.
- Sits directly upstream of the macro; every macro port is driven from this block.

Parameters:
- ADDR_W, 12, SRAM address width (4096 entries).
- DATA_W, 137, SRAM word width.
- RESP_DEPTH, 2, response buffer entries; minimum 2; power of two.

Ports:
- clock  in  1  sole clock; also drives the macro's RW0_clk.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDR_W  read address.
- resp_valid  out  1  read response valid.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  DATA_W  read response data, in request order.
- mem_addr  out  ADDR_W  to RW0_addr.
- mem_en  out  1  to RW0_en.
- mem_wmode  out  1  to RW0_wmode.
- mem_wdata  out  DATA_W  to RW0_wdata.
- mem_rdata  in  DATA_W  from RW0_rdata.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - resp_valid=0, wr_ready=0, rd_ready=0, mem_en=0.
  - inflight=0, buffer count=0, last_grant=READ (so the first contention after reset goes to write).
  - Asserting reset mid-operation drops any in-flight read and all buffered responses; no response is emitted for them.
- Read eligibility: rd_elig = rd_valid && (count + inflight < RESP_DEPTH).
- Arbitration (combinational, same cycle):
  - Only wr_valid: grant write.
  - Only rd_elig: grant read.
  - Both: grant the opposite of last_grant, then update last_grant.
  - last_grant updates only on contended cycles.
  - wr_ready and rd_ready are both 0 while reset is high.
- Write grant: mem_en=1, mem_wmode=1, mem_addr=wr_addr, wr_ready=1. The SRAM updates at that edge.
- Read grant: mem_en=1, mem_wmode=0, mem_addr=rd_addr, rd_ready=1. inflight<=1 at the next edge; otherwise inflight<=0.
- Idle: mem_en=0, mem_wmode=0.
- mem_wdata = wr_data unconditionally.
- Latency: read accepted in cycle T; mem_rdata is valid in cycle T+1 only. It is captured or forwarded in T+1 and never sampled later, because a later write can alter the addressed entry.
- Response path (flow-through):
  - In T+1 with count==0: resp_valid=1, resp_data=mem_rdata. If resp_ready=1, no push; otherwise push mem_rdata into the buffer.
  - In T+1 with count>0: the buffer head is presented and mem_rdata is pushed at the tail.
  - Push and pop in the same cycle leave count unchanged.
- Response buffer:
  - Circular buffer with wrap-around pointers; count width clog2(RESP_DEPTH)+1.
  - The credit rule guarantees it never overflows. Overflow is an assertion failure.
- Ordering:
  - Responses are returned in request acceptance order.
  - A read accepted after a write to the same address returns the new data.
  - A read accepted before a write returns the old data.
- Throughput: with resp_ready held high and only reads, one read per cycle is sustained.
- Stall: with resp_ready=0, rd_ready deasserts after RESP_DEPTH outstanding reads. Writes continue unaffected.

Decomposition:
- Package array_19_pkg holds ADDR_W/DATA_W defaults, the grant enum {GRANT_WRITE, GRANT_READ}, and the RESP_DEPTH minimum constant.
- One sub-module, array_19_resp_fifo: synchronous FIFO with push, pop, head data, count and full/empty flags. The top-level block holds arbitration, credit and flow-through logic.

Test Plan:
- Reset: hold reset 3 cycles with wr_valid=rd_valid=1 -> mem_en=0, wr_ready=rd_ready=0, resp_valid=0 throughout.
- Write then read: write 0x0AB data 0x1_2345 in cycle 0, read 0x0AB in cycle 1 -> resp_valid=1 with resp_data=0x1_2345 in cycle 2.
- Contention: wr_valid and rd_valid held continuously from reset -> grants alternate W,R,W,R. Four reads of distinct preloaded addresses return in order.
- Backpressure: resp_ready=0, issue reads to 0x000/0x001/0x002 -> only two accepted, rd_ready=0 on the third. Release resp_ready -> data for 0x000 then 0x001, then the third read is accepted.
- Hazard: read 0x7FF accepted, then the next cycle a write of 0x7FF with new data while resp_ready=0 -> buffered response holds the old value.
- Reset mid-flight: read accepted, reset asserted next cycle -> no resp_valid after reset releases, count=0.

Source files
------------

// File: rtl/array_19_pkg.sv
// Shared defaults and types for the array_19 SRAM front-end.
package array_19_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 12;
   localparam int unsigned DATA_W_DEFAULT = 137;
   localparam int unsigned RESP_DEPTH_MIN = 2;

   typedef enum logic {
      GRANT_WRITE = 1'b0,
      GRANT_READ  = 1'b1
   } grant_e;

endpackage

// File: rtl/array_19_port_ctrl_if.sv
// Request/response streams plus the RW0 macro port of the array_19 controller.
interface array_19_port_ctrl_if
   import array_19_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT
);

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_en;
   logic              mem_wmode;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Client side: issues requests, consumes responses and models the macro
   modport master (
      output wr_valid, wr_addr, wr_data,
      output rd_valid, rd_addr,
      output resp_ready,
      output mem_rdata,
      input  wr_ready, rd_ready, resp_valid, resp_data,
      input  mem_addr, mem_en, mem_wmode, mem_wdata
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      input  rd_valid, rd_addr,
      input  resp_ready,
      input  mem_rdata,
      output wr_ready, rd_ready, resp_valid, resp_data,
      output mem_addr, mem_en, mem_wmode, mem_wdata
   );

endinterface

// File: rtl/array_19_resp_fifo.sv
// Circular response buffer; storage is not reset, only pointers and count.
module array_19_resp_fifo
   import array_19_pkg::*;
#(
   parameter  int unsigned DEPTH  = RESP_DEPTH_MIN,
   parameter  int unsigned DATA_W = DATA_W_DEFAULT,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] store [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= wdata;
   end

   always_comb begin
      rdata = store[rd_ptr];
      full  = (count == CNT_W'(DEPTH));
      empty = (count == '0);
   end

endmodule

// File: rtl/array_19_port_ctrl.sv
// Arbitrates write and read-request streams onto the single RW0 port of
// array_19_ext and returns read data in order through a credit-limited buffer.
module array_19_port_ctrl
   import array_19_pkg::*;
#(
   parameter  int unsigned ADDR_W     = ADDR_W_DEFAULT,
   parameter  int unsigned DATA_W     = DATA_W_DEFAULT,
   parameter  int unsigned RESP_DEPTH = RESP_DEPTH_MIN,
   localparam int unsigned CNT_W      = $clog2(RESP_DEPTH) + 1
) (
   input logic                 clock,
   input logic                 reset,
   array_19_port_ctrl_if.slave bus
);

   grant_e            last_grant;
   logic              inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              push;
   logic              pop;
   logic [31:0]       credits_used;
   logic              rd_elig;
   logic              wr_req;
   logic              rd_req;
   logic              contended;
   logic              gnt_wr;
   logic              gnt_rd;

   // A read is only eligible while a buffer slot is guaranteed for its data
   always_comb begin
      credits_used = 32'(fifo_count) + 32'(inflight);
      rd_elig      = bus.rd_valid && (credits_used < RESP_DEPTH);
      wr_req       = bus.wr_valid && !reset;
      rd_req       = rd_elig && !reset;
      contended    = wr_req && rd_req;
      gnt_wr       = wr_req && (!rd_req || (last_grant == GRANT_READ));
      gnt_rd       = rd_req && (!wr_req || (last_grant == GRANT_WRITE));
   end

   always_comb begin
      bus.wr_ready  = gnt_wr;
      bus.rd_ready  = gnt_rd;
      bus.mem_en    = gnt_wr || gnt_rd;
      bus.mem_wmode = gnt_wr;
      bus.mem_addr  = gnt_rd ? bus.rd_addr : bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
   end

   // mem_rdata is only valid the cycle after acceptance: forward it when the
   // buffer is empty and the consumer is ready, otherwise capture it now.
   always_comb begin
      bus.resp_valid = !reset && (!fifo_empty || inflight);
      bus.resp_data  = fifo_empty ? bus.mem_rdata : fifo_head;
      pop            = !reset && !fifo_empty && bus.resp_ready;
      push           = !reset && inflight && (!fifo_empty || !bus.resp_ready);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         inflight   <= 1'b0;
         last_grant <= GRANT_READ;
      end else begin
         inflight <= gnt_rd;
         if (contended) last_grant <= gnt_wr ? GRANT_WRITE : GRANT_READ;
      end
   end

   array_19_resp_fifo #(
      .DEPTH  (RESP_DEPTH),
      .DATA_W (DATA_W)
   ) u_resp_fifo (
      .clk   (clock),
      .rst   (reset),
      .push  (push),
      .pop   (pop),
      .wdata (bus.mem_rdata),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push && fifo_full && !pop));

   a_depth_legal: assert property (@(posedge clock)
      (RESP_DEPTH >= RESP_DEPTH_MIN) && ((RESP_DEPTH & (RESP_DEPTH - 1)) == 0));

endmodule

// File: tb/tb_array_19_port_ctrl.sv
// Directed bench for array_19_port_ctrl with a behavioural RW0 macro and a
// response scoreboard.
module tb_array_19_port_ctrl;
   import array_19_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 137;

   logic clock;
   logic reset;

   array_19_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   array_19_port_ctrl #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .RESP_DEPTH (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural single-port macro with 1-cycle read latency
   logic [DW-1:0] sram   [4096];
   logic [DW-1:0] shadow [4096];

   always @(posedge clock) begin
      if (bus.mem_en) begin
         if (bus.mem_wmode) sram[bus.mem_addr] <= bus.mem_wdata;
         else               bus.mem_rdata      <= sram[bus.mem_addr];
      end
   end

   int unsigned   n_checks;
   int unsigned   n_fail;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] hz_new;

   function automatic logic [DW-1:0] pat(input int unsigned a);
      return {9'h1A5, 32'(a) ^ 32'hC0DE_0000, 32'(a) * 32'd7, 64'h0123_4567_89AB_CDEF + 64'(a)};
   endfunction

   function automatic logic [DW-1:0] rnd137();
      return {9'($urandom), $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Sample mid-cycle: update the reference memory on observed grants and
   // score any response handed over this cycle.
   task automatic sample();
      #3;
      if (bus.rd_ready) exp_q.push_back(shadow[bus.rd_addr]);
      if (bus.wr_ready) shadow[bus.wr_addr] = bus.wr_data;
      if (bus.resp_valid && bus.resp_ready) begin
         if (exp_q.size() == 0) check("resp_unexpected", DW'(exp_q.size()), DW'(1));
         else                   check("resp_data", bus.resp_data, exp_q.pop_front());
      end
   endtask

   task automatic next();
      @(negedge clock);
   endtask

   task automatic step();
      sample();
      next();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 4096; i++) begin
         sram[i]   = pat(i);
         shadow[i] = pat(i);
      end
      hz_new         = rnd137();
      reset          = 1'b1;
      bus.wr_valid   = 1'b1;
      bus.rd_valid   = 1'b1;
      bus.wr_addr    = 12'h300;
      bus.wr_data    = rnd137();
      bus.rd_addr    = 12'h010;
      bus.resp_ready = 1'b1;

      // Reset held with both requests pending
      for (int c = 0; c < 3; c++) begin
         sample();
         check("rst_mem_en",     bus.mem_en,     DW'(0));
         check("rst_wr_ready",   bus.wr_ready,   DW'(0));
         check("rst_rd_ready",   bus.rd_ready,   DW'(0));
         check("rst_resp_valid", bus.resp_valid, DW'(0));
         next();
      end

      // Continuous contention straight out of reset: W,R,W,R,...
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.wr_addr = 12'(32'h300 + i);
         bus.wr_data = rnd137();
         bus.rd_addr = 12'(32'h010 + i / 2);
         sample();
         check("cont_wr_ready", bus.wr_ready, DW'(i % 2 == 0));
         check("cont_rd_ready", bus.rd_ready, DW'(i % 2 == 1));
         next();
      end
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b0;
      step();
      step();

      // Write then read the same address
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 12'h0AB;
      bus.wr_data  = DW'(32'h1_2345);
      sample();
      check("wr_ready",     bus.wr_ready,  DW'(1));
      check("wr_mem_wmode", bus.mem_wmode, DW'(1));
      check("wr_mem_addr",  bus.mem_addr,  DW'(12'h0AB));
      next();
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 12'h0AB;
      sample();
      check("rd_ready",     bus.rd_ready,  DW'(1));
      check("rd_mem_en",    bus.mem_en,    DW'(1));
      check("rd_mem_wmode", bus.mem_wmode, DW'(0));
      next();
      bus.rd_valid = 1'b0;
      sample();
      check("wr_rd_resp_valid", bus.resp_valid, DW'(1));
      check("wr_rd_resp_data",  bus.resp_data,  DW'(32'h1_2345));
      next();

      // Backpressure: only two reads fit while the consumer stalls
      bus.resp_ready = 1'b0;
      bus.rd_valid   = 1'b1;
      bus.rd_addr    = 12'h000;
      sample(); check("bp_rd0_ready", bus.rd_ready, DW'(1)); next();
      bus.rd_addr = 12'h001;
      sample(); check("bp_rd1_ready", bus.rd_ready, DW'(1)); next();
      bus.rd_addr = 12'h002;
      sample(); check("bp_rd2_blocked", bus.rd_ready, DW'(0)); next();
      sample();
      check("bp_rd2_still_blocked", bus.rd_ready,   DW'(0));
      check("bp_resp_valid",        bus.resp_valid, DW'(1));
      check("bp_head_data",         bus.resp_data,  pat(0));
      next();
      bus.resp_ready = 1'b1;
      sample(); check("bp_release_blocked", bus.rd_ready, DW'(0)); next();
      sample(); check("bp_rd2_accepted",    bus.rd_ready, DW'(1)); next();
      bus.rd_valid = 1'b0;
      step();
      step();

      // Read-before-write hazard: buffered response keeps the old value
      bus.resp_ready = 1'b0;
      bus.rd_valid   = 1'b1;
      bus.rd_addr    = 12'h7FF;
      sample(); check("hz_rd_ready", bus.rd_ready, DW'(1)); next();
      bus.rd_valid = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 12'h7FF;
      bus.wr_data  = hz_new;
      sample();
      check("hz_wr_ready",   bus.wr_ready,   DW'(1));
      check("hz_resp_valid", bus.resp_valid, DW'(1));
      next();
      bus.wr_valid = 1'b0;
      sample();
      check("hz_buffered_valid", bus.resp_valid, DW'(1));
      check("hz_buffered_old",   bus.resp_data,  pat(32'h7FF));
      next();
      bus.resp_ready = 1'b1;
      step();
      bus.rd_valid = 1'b1;
      step();
      bus.rd_valid = 1'b0;
      sample(); check("hz_reread_new", bus.resp_data, hz_new); next();

      // Reset while a read is in flight
      bus.rd_valid = 1'b1;
      bus.rd_addr  = 12'h005;
      sample(); check("mf_rd_ready", bus.rd_ready, DW'(1)); next();
      reset        = 1'b1;
      bus.rd_valid = 1'b0;
      sample(); check("mf_resp_in_reset", bus.resp_valid, DW'(0)); next();
      exp_q.delete();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         sample(); check("mf_no_resp", bus.resp_valid, DW'(0)); next();
      end
      check("mf_fifo_count", DW'(dut.fifo_count), DW'(0));
      check("mf_inflight",   DW'(dut.inflight),   DW'(0));

      // First contention after reset goes to write again
      bus.wr_valid = 1'b1;
      bus.rd_valid = 1'b1;
      bus.wr_addr  = 12'h400;
      bus.wr_data  = rnd137();
      bus.rd_addr  = 12'h020;
      sample();
      check("mf_cont_wr", bus.wr_ready, DW'(1));
      check("mf_cont_rd", bus.rd_ready, DW'(0));
      next();
      sample();
      check("mf_cont2_wr", bus.wr_ready, DW'(0));
      check("mf_cont2_rd", bus.rd_ready, DW'(1));
      next();
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b0;
      for (int c = 0; c < 3; c++) step();

      check("scoreboard_empty", DW'(exp_q.size()), DW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
